// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus, aligns and extends load data,
// and registers the result toward writeback while holding the pipe for the duration of a transfer.
module mem_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid_i,
  input  logic          flush_i,
  input  logic [31:0]   inst_i,
  input  logic [31:0]   instaddr_i,
  input  logic          cs_i,
  input  logic          mem_we_i,
  input  logic [3:0]    mem_wem_i,
  input  logic [DW-1:0] mem_din_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic          regs_wen_i,
  input  logic [4:0]    rd_addr_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [3:0]    dbus_be_o,
  output logic [AW-1:0] dbus_addr_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_gnt_i,
  input  logic          dbus_rvalid_i,
  input  logic [DW-1:0] dbus_rdata_i,
  input  logic          dbus_err_i,
  output logic          stall_o,
  output logic          valid_o,
  output logic [31:0]   inst_o,
  output logic [31:0]   instaddr_o,
  output logic          regs_wen_o,
  output logic [4:0]    rd_addr_o,
  output logic [DW-1:0] rd_data_o,
  output logic          misalign_o,
  output logic          buserr_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_r, state_s;
  logic            we_r, flush_r, flush_s;
  logic [3:0]      be_r;
  logic [AW-3:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [2:0]      f3_r;
  logic [1:0]      off_r;
  logic [2:0]      f3_s;
  logic            misalign_s, issue_s;
  logic            valid_s, regs_wen_s, mis_pulse_s, buserr_s, kill_s;
  logic [DW-1:0]   rd_data_s;

  // Select the addressed byte/half of the bus word and sign- or zero-extend it by funct3.
  function automatic logic [DW-1:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DW-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b010:  load_align = rdata;
      3'b100:  load_align = {24'h000000, b};
      3'b101:  load_align = {16'h0000, h};
      default: load_align = rdata;
    endcase
  endfunction

  assign f3_s       = inst_i[14:12];
  assign misalign_s = ((f3_s[1:0] == 2'b01) & mem_addr_i[0]) |
                      ((f3_s[1:0] == 2'b10) & (mem_addr_i[1:0] != 2'b00));
  assign issue_s    = (state_r == IDLE) & valid_i & cs_i & ~flush_i & ~misalign_s;
  assign stall_o    = issue_s | (state_r == REQ) | ((state_r == WAIT) & ~dbus_rvalid_i);
  // A flush seen mid-transfer must survive until the response arrives.
  assign flush_s    = (state_s != IDLE) & (flush_r | flush_i);
  assign kill_s     = flush_r | flush_i;

  assign dbus_req_o   = (state_r == REQ);
  assign dbus_we_o    = we_r;
  assign dbus_be_o    = be_r;
  assign dbus_addr_o  = {addr_r, 2'b00};
  assign dbus_wdata_o = wdata_r;

  // Next-state decode for the bus handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (issue_s) state_s = REQ; else state_s = IDLE;
      REQ:     if (dbus_gnt_i) state_s = WAIT; else state_s = REQ;
      WAIT:    if (dbus_rvalid_i) state_s = IDLE; else state_s = WAIT;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the writeback-facing result registers.
  always_comb begin
    valid_s     = 1'b0;
    regs_wen_s  = 1'b0;
    mis_pulse_s = 1'b0;
    buserr_s    = 1'b0;
    rd_data_s   = rd_data_i;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          valid_s = 1'b0;
        end else if (valid_i & cs_i & ~flush_i) begin
          valid_s     = 1'b1;
          mis_pulse_s = 1'b1;
        end else begin
          valid_s    = valid_i & ~flush_i;
          regs_wen_s = valid_i & ~flush_i & regs_wen_i;
        end
      end
      WAIT: begin
        if (dbus_rvalid_i) begin
          valid_s    = ~kill_s;
          regs_wen_s = ~kill_s & ~dbus_err_i & regs_wen_i;
          buserr_s   = ~kill_s & dbus_err_i;
          rd_data_s  = we_r ? rd_data_i : load_align(f3_r, off_r, dbus_rdata_i);
        end else begin
          valid_s = 1'b0;
        end
      end
      default: valid_s = 1'b0;
    endcase
  end

  // State, captured request fields and registered stage outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      flush_r    <= 1'b0;
      be_r       <= 4'h0;
      addr_r     <= {(AW-2){1'b0}};
      wdata_r    <= {DW{1'b0}};
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
      valid_o    <= 1'b0;
      inst_o     <= 32'h0000_0000;
      instaddr_o <= 32'h0000_0000;
      regs_wen_o <= 1'b0;
      rd_addr_o  <= 5'd0;
      rd_data_o  <= {DW{1'b0}};
      misalign_o <= 1'b0;
      buserr_o   <= 1'b0;
    end else begin
      state_r <= state_s;
      flush_r <= flush_s;
      if (issue_s) begin
        we_r    <= mem_we_i;
        be_r    <= mem_wem_i;
        addr_r  <= mem_addr_i[AW-1:2];
        wdata_r <= mem_din_i;
        f3_r    <= f3_s;
        off_r   <= mem_addr_i[1:0];
      end
      valid_o    <= valid_s;
      inst_o     <= inst_i;
      instaddr_o <= instaddr_i;
      regs_wen_o <= regs_wen_s;
      rd_addr_o  <= rd_addr_i;
      rd_data_o  <= rd_data_s;
      misalign_o <= mis_pulse_s;
      buserr_o   <= buserr_s;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table of single memory/ALU ops driven through a small bus
// responder, plus hand sequences for flush and reset corner cases.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_i, flush_i, cs_i, mem_we_i, regs_wen_i;
  logic [31:0] inst_i, instaddr_i, mem_din_i, mem_addr_i, rd_data_i;
  logic [3:0]  mem_wem_i;
  logic [4:0]  rd_addr_i;
  logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic        stall_o, valid_o, regs_wen_o, misalign_o, buserr_o;
  logic [31:0] inst_o, instaddr_o, rd_data_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .flush_i(flush_i), .inst_i(inst_i),
    .instaddr_i(instaddr_i), .cs_i(cs_i), .mem_we_i(mem_we_i), .mem_wem_i(mem_wem_i),
    .mem_din_i(mem_din_i), .mem_addr_i(mem_addr_i), .regs_wen_i(regs_wen_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_be_o(dbus_be_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i), .stall_o(stall_o),
    .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o),
    .buserr_o(buserr_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        cs;
    logic        we;
    logic [3:0]  wem;
    logic [31:0] din;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        wen;
    logic [31:0] rd_data;
    int          gd;
    logic        bus;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_valid;
    logic        exp_wen;
    logic        exp_mis;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; flush_i = 1'b0; cs_i = 1'b0; mem_we_i = 1'b0; regs_wen_i = 1'b0;
    inst_i = 32'h0; instaddr_i = 32'h0; mem_din_i = 32'h0; mem_addr_i = 32'h0;
    rd_data_i = 32'h0; mem_wem_i = 4'h0; rd_addr_i = 5'd0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'h0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic cs, input logic we,
                          input logic [31:0] addr, input logic [31:0] rdd, input logic wen);
    valid_i = 1'b1; cs_i = cs; mem_we_i = we; mem_addr_i = addr; rd_data_i = rdd;
    regs_wen_i = wen; rd_addr_i = 5'd7; mem_wem_i = 4'hF;
    inst_i = {17'h0, f3, 5'd7, (cs ? (we ? 7'h23 : 7'h03) : 7'h13)};
    instaddr_i = 32'h0000_1000;
  endtask

  // Applies one vector from a negedge, answering the bus, and checks the registered result.
  task automatic run_vec(input vec_t v);
    int  nreq, nstall, cnt;
    bit  gnt_seen, done;
    drive_op(v.f3, v.cs, v.we, v.addr, v.rd_data, v.wen);
    mem_wem_i = v.wem; mem_din_i = v.din;
    if (!v.bus) begin
      #1;
      chk({v.name, " stall"}, {31'h0, stall_o}, 32'h0);
      chk({v.name, " noreq"}, {31'h0, dbus_req_o}, 32'h0);
      @(posedge clk); @(negedge clk);
    end else begin
      nreq = 0; nstall = 0; cnt = 0; gnt_seen = 1'b0; done = 1'b0;
      while (!done && cnt < 40) begin
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'h0;
        if (gnt_seen) begin
          dbus_rvalid_i = 1'b1; dbus_rdata_i = v.rdata; dbus_err_i = v.err; done = 1'b1;
        end else if (dbus_req_o) begin
          nreq++;
          chk({v.name, " addr"}, dbus_addr_o, {v.addr[31:2], 2'b00});
          chk({v.name, " be"}, {28'h0, dbus_be_o}, {28'h0, v.wem});
          chk({v.name, " we"}, {31'h0, dbus_we_o}, {31'h0, v.we});
          if (v.we) chk({v.name, " wdata"}, dbus_wdata_o, v.din);
          if (nreq > v.gd) begin
            dbus_gnt_i = 1'b1; gnt_seen = 1'b1;
          end
        end
        #1;
        if (stall_o) nstall++;
        @(posedge clk); @(negedge clk);
        cnt++;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL %s timeout got=no_rvalid exp=rvalid", v.name);
      end
      chk({v.name, " reqcyc"}, nreq, v.gd + 1);
      chk({v.name, " stallcyc"}, nstall, v.gd + 2);
    end
    drive_idle();
    chk({v.name, " valid"}, {31'h0, valid_o}, {31'h0, v.exp_valid});
    chk({v.name, " wen"}, {31'h0, regs_wen_o}, {31'h0, v.exp_wen});
    chk({v.name, " mis"}, {31'h0, misalign_o}, {31'h0, v.exp_mis});
    chk({v.name, " berr"}, {31'h0, buserr_o}, {31'h0, v.exp_berr});
    if (v.chk_rd) chk({v.name, " rd"}, rd_data_o, v.exp_rd);
    @(posedge clk); @(negedge clk);
    chk({v.name, " pulse"}, {29'h0, valid_o, misalign_o, buserr_o}, 32'h0);
  endtask

  initial begin
    //        name   f3     cs    we    wem    din           addr          rdata         err   wen   rd_data       gd bus   exp_rd        chk   v     wen   mis   berr
    vecs[0]  = '{"LW",   3'b010,1'b1,1'b0,4'hF,32'h0,       32'h100,      32'hDEADBEEF, 1'b0,1'b1,32'h100,      0,1'b1,32'hDEADBEEF,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[1]  = '{"LB",   3'b000,1'b1,1'b0,4'hF,32'h0,       32'h103,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'hFFFFFF80,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[2]  = '{"LBU",  3'b100,1'b1,1'b0,4'hF,32'h0,       32'h103,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'h00000080,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[3]  = '{"LHU",  3'b101,1'b1,1'b0,4'hF,32'h0,       32'h102,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'h000080FF,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[4]  = '{"LH",   3'b001,1'b1,1'b0,4'hF,32'h0,       32'h102,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'hFFFF80FF,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[5]  = '{"LB0",  3'b000,1'b1,1'b0,4'hF,32'h0,       32'h100,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'h0000007F,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[6]  = '{"LH0",  3'b001,1'b1,1'b0,4'hF,32'h0,       32'h100,      32'h80FFFF7F, 1'b0,1'b1,32'h0,        0,1'b1,32'hFFFFFF7F,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[7]  = '{"LBU1", 3'b100,1'b1,1'b0,4'hF,32'h0,       32'h101,      32'h12345678, 1'b0,1'b1,32'h0,        2,1'b1,32'h00000056,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[8]  = '{"SW",   3'b010,1'b1,1'b1,4'hF,32'h12345678,32'h20,       32'h0,        1'b0,1'b0,32'h20,       3,1'b1,32'h00000020,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[9]  = '{"SB",   3'b000,1'b1,1'b1,4'h2,32'h0000AB00,32'h21,       32'h0,        1'b0,1'b0,32'h21,       1,1'b1,32'h00000021,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[10] = '{"LWmis",3'b010,1'b1,1'b0,4'hF,32'h0,       32'h102,      32'h0,        1'b0,1'b1,32'h0,        0,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b1,1'b0};
    vecs[11] = '{"LHmis",3'b001,1'b1,1'b0,4'hF,32'h0,       32'h101,      32'h0,        1'b0,1'b1,32'h0,        0,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b1,1'b0};
    vecs[12] = '{"SHmis",3'b001,1'b1,1'b1,4'hC,32'h0,       32'h23,       32'h0,        1'b0,1'b0,32'h0,        0,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b1,1'b0};
    vecs[13] = '{"LWerr",3'b010,1'b1,1'b0,4'hF,32'h0,       32'h104,      32'h0,        1'b1,1'b1,32'h0,        0,1'b1,32'h0,       1'b0,1'b1,1'b0,1'b0,1'b1};
    vecs[14] = '{"ADDI", 3'b000,1'b0,1'b0,4'h0,32'h0,       32'h0,        32'h0,        1'b0,1'b1,32'h55,       0,1'b0,32'h00000055,1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[15] = '{"LW2",  3'b010,1'b1,1'b0,4'hF,32'h0,       32'h200,      32'hCAFEF00D, 1'b0,1'b1,32'h0,        1,1'b1,32'hCAFEF00D,1'b1,1'b1,1'b1,1'b0,1'b0};

    drive_idle();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #3;
    chk("rst valid", {31'h0, valid_o}, 32'h0);
    chk("rst req", {31'h0, dbus_req_o}, 32'h0);
    chk("rst rd", rd_data_o, 32'h0);
    chk("rst stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // flush in IDLE: nothing issued, bubble out
    drive_op(3'b010, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("fidle stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); @(negedge clk);
    drive_idle();
    chk("fidle valid", {31'h0, valid_o}, 32'h0);
    chk("fidle wen", {31'h0, regs_wen_o}, 32'h0);
    chk("fidle req", {31'h0, dbus_req_o}, 32'h0);

    // flush in WAIT: response consumed, result discarded, then an ADDI flows normally
    drive_op(3'b010, 1'b1, 1'b0, 32'h304, 32'h0, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("fwait req", {31'h0, dbus_req_o}, 32'h1);
    dbus_gnt_i = 1'b1;
    @(posedge clk); @(negedge clk);
    dbus_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fwait stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk); @(negedge clk);
    flush_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    #1;
    chk("fwait stall_rv", {31'h0, stall_o}, 32'h0);
    @(posedge clk); @(negedge clk);
    drive_idle();
    chk("fwait valid", {31'h0, valid_o}, 32'h0);
    chk("fwait wen", {31'h0, regs_wen_o}, 32'h0);
    drive_op(3'b000, 1'b0, 1'b0, 32'h0, 32'h77, 1'b1);
    @(posedge clk); @(negedge clk);
    drive_idle();
    chk("addi valid", {31'h0, valid_o}, 32'h1);
    chk("addi wen", {31'h0, regs_wen_o}, 32'h1);
    chk("addi rd", rd_data_o, 32'h77);

    // reset while in WAIT: outputs clear asynchronously, later rvalid ignored
    drive_op(3'b010, 1'b1, 1'b0, 32'h400, 32'hABCD, 1'b1);
    @(posedge clk); @(negedge clk);
    dbus_gnt_i = 1'b1;
    @(posedge clk); @(negedge clk);
    drive_idle();
    chk("prerst rd", rd_data_o, 32'hABCD);
    rstn = 1'b0;
    #1;
    chk("rstw rd", rd_data_o, 32'h0);
    chk("rstw inst", inst_o, 32'h0);
    chk("rstw be", {28'h0, dbus_be_o}, 32'h0);
    chk("rstw addr", dbus_addr_o, 32'h0);
    chk("rstw stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk) rstn = 1'b1;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h2222_2222;
    #1;
    chk("rstw stall_rv", {31'h0, stall_o}, 32'h0);
    @(posedge clk); @(negedge clk);
    drive_idle();
    chk("rstw valid", {31'h0, valid_o}, 32'h0);
    chk("rstw rd2", rd_data_o, 32'h0);
    chk("rstw req", {31'h0, dbus_req_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
